vc_pop_arbiter: RTL and testbench
=================================

# vc_pop_arbiter

Two-virtual-channel pop arbiter sitting directly downstream of the VC0/VC1 FIFO control stages. Each cycle it selects at most one non-empty source FIFO, pops its head word and forwards it, one cycle later, as a push into one of two destination FIFOs. The destination is chosen by the word's class bit. VC0 has priority, with a bounded-starvation guarantee for VC1, and pops are gated by destination `almost_full` backpressure.

## Interface
- `WORD_SIZE`, 10, data word width; bit `WORD_SIZE-1` is the destination class bit (0 → D0, 1 → D1).
- `STARVE_MAX`, 4, max consecutive VC0 grants while VC1 is eligible (legal 1..7).

- `clk` in 1: single clock; all state updates on rising edge.
- `reset_L` in 1: asynchronous, active-low reset.
- `enable` in 1: arbitration enable; 0 stops new pops.
- `vc0_fifo_empty` in 1: VC0 source FIFO empty flag.
- `vc1_fifo_empty` in 1: VC1 source FIFO empty flag.
- `vc0_data_in` in WORD_SIZE: VC0 head word (first-word-fall-through, valid when not empty).
- `vc1_data_in` in WORD_SIZE: VC1 head word.
- `d0_almost_full` in 1: destination D0 backpressure.
- `d1_almost_full` in 1: destination D1 backpressure.
- `vc0_fifo_rd` out 1: pop VC0 this cycle.
- `vc1_fifo_rd` out 1: pop VC1 this cycle.
- `d0_push` out 1: write `data_out` into D0.
- `d1_push` out 1: write `data_out` into D1.
- `data_out` out WORD_SIZE: registered forwarded word.
- `idle_out` out 1: state IDLE and no push in flight.

## Operation
- Eligibility (combinational): `elig0 = !vc0_fifo_empty && !dN_almost_full`, where N = `vc0_data_in[WORD_SIZE-1]`. `elig1` is defined likewise for VC1.
- Grant, evaluated only in ACTIVE with `enable` = 1:
  - elig0 only → VC0.
  - elig1 only → VC1.
  - Both eligible → VC0, unless `starve_cnt == STARVE_MAX`, in which case VC1.
- `vcX_fifo_rd` is combinational and equals the grant. It is never asserted for both channels, never when the source is empty, and is forced 0 while `reset_L` = 0.
- On a grant, the head word is registered into `data_out` at the edge, and `d0_push`/`d1_push` is set by the class bit for exactly one cycle. Push is 0 in every cycle without a preceding grant.
- `starve_cnt` (3-bit):
  - +1 on a VC0 grant while elig1 = 1, saturating at STARVE_MAX.
  - Cleared on any VC1 grant.
  - Otherwise holds.
- FSM states:
  - IDLE → ACTIVE when `enable && (elig0 || elig1)`.
  - ACTIVE → IDLE when `!enable` or no channel is eligible. Pops are not issued in the transition cycle.
  - IDLE with `enable && eligible` moves to ACTIVE; the first pop issues in the cycle after entry.
- `enable` deasserted mid-stream: no new pop from that cycle on; an already-registered push still completes next cycle.
- System requirement: each destination's almost_full threshold must leave ≥2 free entries, because a push lands one cycle after the pop decision.

## Timing
- Reset values, applied asynchronously on `reset_L` low:
  - State IDLE, `starve_cnt` = 0.
  - `data_out` = 0, `d0_push` = `d1_push` = 0.
  - `vc0_fifo_rd` = `vc1_fifo_rd` = 0, `idle_out` = 1.
- Reset is released synchronously at the next edge.
- Reset asserted mid-operation discards any in-flight push; its word is lost, and upstream is expected to reset too.
- Pop-to-push latency is 1 cycle. Sustained throughput is 1 word/cycle.
- Backpressure: `almost_full` is sampled in the same cycle as the pop decision. A destination rising at cycle T blocks pops from T onward; a push already registered at T still occurs at T+1.
- `idle_out` is 0 in ACTIVE, and also in the cycle a push is outstanding.

## Test plan
- Reset mid-stream with a push pending → all outputs return to reset values immediately; no push follows release.
- VC0 holds 3 words (class 0), VC1 empty → `vc0_fifo_rd` high for 3 consecutive cycles; `d0_push` high for the 3 following cycles with the words in order; `idle_out` returns to 1.
- Both FIFOs hold 10 words, STARVE_MAX = 4 → grant pattern is VC0 ×4, VC1 ×1, repeated; `starve_cnt` never exceeds 4.
- VC0 head class 1 with `d1_almost_full` = 1, VC1 head class 0 → only VC1 pops; VC0 pops resume the cycle after `d1_almost_full` falls.
- Both FIFOs empty, one VC0 pop requested → no rd asserted and no push; `idle_out` stays 1.
- `enable` dropped while streaming → rd stops the same cycle; exactly one trailing push; state IDLE.

Source files
------------

// File: rtl/vc_pop_arbiter.sv
// Two-VC pop arbiter: pops at most one eligible source FIFO per cycle and
// forwards the head word one cycle later as a push into the destination
// FIFO selected by the word's class bit. VC0 has priority, but VC1 is
// guaranteed a grant after STARVE_MAX consecutive VC0 grants.

// Per-VC eligibility: the source has a word and its destination has room.
module vc_pop_elig #(
  parameter int WORD_SIZE = 10
) (
  input  logic                 fifo_empty,
  input  logic [WORD_SIZE-1:0] head,
  input  logic [1:0]           dst_af,
  output logic                 elig
);
  assign elig = !fifo_empty && !dst_af[head[WORD_SIZE-1]];
endmodule

module vc_pop_arbiter #(
  parameter int WORD_SIZE  = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic                 vc0_fifo_empty,
  input  logic                 vc1_fifo_empty,
  input  logic [WORD_SIZE-1:0] vc0_data_in,
  input  logic [WORD_SIZE-1:0] vc1_data_in,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  output logic                 vc0_fifo_rd,
  output logic                 vc1_fifo_rd,
  output logic                 d0_push,
  output logic                 d1_push,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 idle_out
);

  localparam int NUM_LANES = 2;
  localparam int STAGES    = 1;   // pop-to-push latency

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                              state;
  logic [2:0]                          starve_cnt;
  logic [NUM_LANES-1:0]                fifo_empty;
  logic [NUM_LANES-1:0]                elig;
  logic [NUM_LANES-1:0]                grant;
  logic [NUM_LANES-1:0][WORD_SIZE-1:0] head;
  logic [1:0]                          dst_af;
  logic [STAGES:1]                     vld_pipe;
  logic                                starved;

  assign fifo_empty = {vc1_fifo_empty, vc0_fifo_empty};
  assign head       = {vc1_data_in, vc0_data_in};
  assign dst_af     = {d1_almost_full, d0_almost_full};
  assign starved    = (starve_cnt == 3'(STARVE_MAX));

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vc_pop_elig #(.WORD_SIZE(WORD_SIZE)) u_elig (
      .fifo_empty (fifo_empty[l]),
      .head       (head[l]),
      .dst_af     (dst_af),
      .elig       (elig[l])
    );
  end

  // Grant: VC0 first unless VC1 has been passed over STARVE_MAX times.
  always_comb begin
    grant = '0;
    if (reset_L && state == ACTIVE && enable) begin
      if (elig[1] && (!elig[0] || starved)) grant[1] = 1'b1;
      else if (elig[0])                     grant[0] = 1'b1;
    end
  end

  assign vc0_fifo_rd = grant[0];
  assign vc1_fifo_rd = grant[1];

  // FSM: ACTIVE while enabled and something is poppable; entry cycle never pops.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (enable && |elig)    state <= ACTIVE;
        ACTIVE:  if (!enable || !(|elig)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation counter: counts VC0 wins over a waiting VC1, cleared when VC1 wins.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                                 starve_cnt <= '0;
    else if (grant[1])                            starve_cnt <= '0;
    else if (grant[0] && elig[1] && !starved)     starve_cnt <= starve_cnt + 3'd1;
  end

  // Forward stage: capture the popped word and mark a push for the next cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      vld_pipe <= '0;
      data_out <= '0;
    end else begin
      vld_pipe[1] <= |grant;
      if (|grant) data_out <= grant[1] ? head[1] : head[0];
    end
  end

  assign d0_push  = vld_pipe[STAGES] && !data_out[WORD_SIZE-1];
  assign d1_push  = vld_pipe[STAGES] &&  data_out[WORD_SIZE-1];
  assign idle_out = (state == IDLE) && !vld_pipe[STAGES];

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter: source FIFOs modelled as queues, a per-cycle
// behavioural model of the expected pops/pushes, and literal expectations
// on the resulting grant/push sequences.
module tb_vc_pop_arbiter;
  localparam int W  = 10;
  localparam int SM = 4;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic         enable = 1'b0;
  logic         vc0_fifo_empty = 1'b1, vc1_fifo_empty = 1'b1;
  logic [W-1:0] vc0_data_in = '0, vc1_data_in = '0;
  logic         d0_af = 1'b0, d1_af = 1'b0;
  logic         vc0_fifo_rd, vc1_fifo_rd, d0_push, d1_push, idle_out;
  logic [W-1:0] data_out;

  vc_pop_arbiter #(.WORD_SIZE(W), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable),
    .vc0_fifo_empty(vc0_fifo_empty), .vc1_fifo_empty(vc1_fifo_empty),
    .vc0_data_in(vc0_data_in), .vc1_data_in(vc1_data_in),
    .d0_almost_full(d0_af), .d1_almost_full(d1_af),
    .vc0_fifo_rd(vc0_fifo_rd), .vc1_fifo_rd(vc1_fifo_rd),
    .d0_push(d0_push), .d1_push(d1_push),
    .data_out(data_out), .idle_out(idle_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  logic [W-1:0] q0[$], q1[$];     // source FIFO contents
  logic [W:0]   plog[$];          // observed pushes {dest, data}
  bit           glog[$];          // observed grants (1 = VC1)

  // model state: "will be active", pending push, forwarded word, starvation
  bit           m_act, m_p0, m_p1;
  int           m_starve;
  logic [W-1:0] m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic refresh();
    vc0_fifo_empty = (q0.size() == 0);
    vc1_fifo_empty = (q1.size() == 0);
    vc0_data_in    = vc0_fifo_empty ? '0 : q0[0];
    vc1_data_in    = vc1_fifo_empty ? '0 : q1[0];
  endtask

  task automatic clear_logs();
    plog.delete();
    glog.delete();
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model,
  // then let the source FIFOs pop what the DUT read.
  task automatic cycle();
    bit e0, e1, c0, c1, g0, g1, p0, p1;
    @(negedge clk);
    if (!reset_L) begin
      m_act = 0; m_p0 = 0; m_p1 = 0; m_starve = 0; m_data = '0;
      chk("rst_data_out", 32'(data_out), 32'(0));
      chk("rst_d0_push", 32'(d0_push), 32'(0));
      chk("rst_d1_push", 32'(d1_push), 32'(0));
      chk("rst_idle", 32'(idle_out), 32'(1));
      chk("rst_rd", 32'({vc1_fifo_rd, vc0_fifo_rd}), 32'(0));
      p0 = 0; p1 = 0;
    end else begin
      chk("d0_push", 32'(d0_push), 32'(m_p0));
      chk("d1_push", 32'(d1_push), 32'(m_p1));
      if (m_p0 || m_p1) chk("data_out", 32'(data_out), 32'(m_data));
      chk("idle_out", 32'(idle_out), 32'(!m_act && !m_p0 && !m_p1));
      if (d0_push) plog.push_back({1'b0, data_out});
      if (d1_push) plog.push_back({1'b1, data_out});
      c0 = vc0_data_in[W-1];
      c1 = vc1_data_in[W-1];
      e0 = !vc0_fifo_empty && !(c0 ? d1_af : d0_af);
      e1 = !vc1_fifo_empty && !(c1 ? d1_af : d0_af);
      g0 = 0; g1 = 0;
      if (m_act && enable) begin
        if (e1 && (!e0 || m_starve >= SM)) g1 = 1;
        else if (e0)                       g0 = 1;
      end
      chk("vc0_fifo_rd", 32'(vc0_fifo_rd), 32'(g0));
      chk("vc1_fifo_rd", 32'(vc1_fifo_rd), 32'(g1));
      if (vc0_fifo_rd || vc1_fifo_rd) glog.push_back(vc1_fifo_rd);
      m_p0 = 0; m_p1 = 0;
      if (g0) begin
        m_data = vc0_data_in; m_p0 = !c0; m_p1 = c0;
        if (e1 && m_starve < SM) m_starve++;
      end
      if (g1) begin
        m_data = vc1_data_in; m_p0 = !c1; m_p1 = c1; m_starve = 0;
      end
      m_act = enable && (e0 || e1);
      p0 = vc0_fifo_rd; p1 = vc1_fifo_rd;
    end
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [19:0] exp_pat;
    refresh();
    run(2);
    reset_L = 1'b1;
    run(1);

    // VC0 holds three class-0 words, VC1 empty
    clear_logs();
    enable = 1'b1;
    q0 = '{10'h011, 10'h022, 10'h033};
    refresh();
    run(8);
    chk("a_grants", 32'(glog.size()), 32'(3));
    chk("a_pushes", 32'(plog.size()), 32'(3));
    if (plog.size() == 3) begin
      chk("a_word0", 32'(plog[0]), 32'({1'b0, 10'h011}));
      chk("a_word1", 32'(plog[1]), 32'({1'b0, 10'h022}));
      chk("a_word2", 32'(plog[2]), 32'({1'b0, 10'h033}));
    end
    chk("a_idle", 32'(idle_out), 32'(1));

    // both empty with enable high: nothing happens
    clear_logs();
    run(4);
    chk("e_grants", 32'(glog.size()), 32'(0));
    chk("e_pushes", 32'(plog.size()), 32'(0));
    chk("e_idle", 32'(idle_out), 32'(1));

    // both hold 10 words: VC0 x4, VC1 x1 until VC0 drains
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(10'(10'h100 + i));
      q1.push_back(10'(10'h080 + i));
    end
    refresh();
    run(24);
    exp_pat = 20'b00001000010011111111;
    chk("s_grants", 32'(glog.size()), 32'(20));
    if (glog.size() == 20)
      for (int i = 0; i < 20; i++) chk($sformatf("s_grant%0d", i), 32'(glog[i]), 32'(exp_pat[19-i]));
    chk("s_pushes", 32'(plog.size()), 32'(20));
    if (plog.size() == 20) chk("s_push4", 32'(plog[4]), 32'({1'b0, 10'h080}));

    // VC0 blocked by d1 backpressure, VC1 flows; VC0 resumes after release
    clear_logs();
    d1_af = 1'b1;
    q0 = '{10'h201, 10'h202};
    q1 = '{10'h011, 10'h012};
    refresh();
    run(6);
    chk("b_blocked_grants", 32'(glog.size()), 32'(2));
    d1_af = 1'b0;
    run(6);
    chk("b_grants", 32'(glog.size()), 32'(4));
    chk("b_pushes", 32'(plog.size()), 32'(4));
    if (plog.size() == 4) begin
      chk("b_push0", 32'(plog[0]), 32'({1'b0, 10'h011}));
      chk("b_push1", 32'(plog[1]), 32'({1'b0, 10'h012}));
      chk("b_push2", 32'(plog[2]), 32'({1'b1, 10'h201}));
      chk("b_push3", 32'(plog[3]), 32'({1'b1, 10'h202}));
    end

    // enable dropped mid-stream: one trailing push, then idle
    clear_logs();
    for (int i = 0; i < 8; i++) q0.push_back(10'(10'h040 + i));
    refresh();
    run(4);
    chk("n_grants", 32'(glog.size()), 32'(3));
    enable = 1'b0;
    run(4);
    chk("n_pushes", 32'(plog.size()), 32'(3));
    chk("n_left", 32'(q0.size()), 32'(5));
    chk("n_idle", 32'(idle_out), 32'(1));
    q0.delete();
    refresh();

    // reset mid-stream with a push pending
    clear_logs();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) q0.push_back(10'(10'h0a0 + i));
    refresh();
    run(3);
    chk("r_pending", 32'(d0_push), 32'(1));
    reset_L = 1'b0;
    q0.delete();
    refresh();
    #1;
    chk("r_push_now", 32'(d0_push), 32'(0));
    chk("r_data_now", 32'(data_out), 32'(0));
    chk("r_idle_now", 32'(idle_out), 32'(1));
    run(1);
    reset_L = 1'b1;
    run(3);
    chk("r_pushes", 32'(plog.size()), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
